// File: rtl/reg_file_2r1w.sv
// Two-read/one-write register file with write-first bypass and a one-entry-per-cycle clear sequencer.
// Latency: reads return 1 cycle after rd_en; clear occupies exactly depth cycles (busy high).
// Backpressure: none; out-of-range writes and writes/clr while busy are dropped. Parity option: REG_FILE_PARITY_EN.
module reg_file_2r1w #(
    parameter int width = 8,
    parameter int depth = 8,
    parameter int aw    = $clog2(depth)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [aw-1:0]    wr_addr,
    input  logic [width-1:0] wr_data,
    input  logic             rd_en_a,
    input  logic [aw-1:0]    rd_addr_a,
    output logic [width-1:0] rd_data_a,
    input  logic             rd_en_b,
    input  logic [aw-1:0]    rd_addr_b,
    output logic [width-1:0] rd_data_b,
    input  logic             clr,
    output logic             busy
`ifdef REG_FILE_PARITY_EN
    ,
    input  logic             par_inj,
    output logic             rd_perr_a,
    output logic             rd_perr_b
`endif
);
    localparam logic [aw:0]   depth_w  = (aw+1)'(depth);
    localparam logic [aw-1:0] last_idx = aw'(depth - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state;
    logic [aw-1:0]    cnt;
    logic [width-1:0] mem [depth];

    logic             clearing;
    logic             wr_acc;
    logic             we_eff;
    logic [aw-1:0]    wa_eff;
    logic [width-1:0] wd_eff;

    // The clear sequencer and external writes share one physical write port.
    assign clearing = (state == CLEAR);
    assign wr_acc   = wr_en && !clearing && ({1'b0, wr_addr} < depth_w);
    assign we_eff   = wr_acc || clearing;
    assign wa_eff   = clearing ? cnt : wr_addr;
    assign wd_eff   = clearing ? '0 : wr_data;

    function automatic logic in_range(input logic [aw-1:0] a);
        return {1'b0, a} < depth_w;
    endfunction

    function automatic logic [width-1:0] rd_val(input logic [aw-1:0] a);
        if (!in_range(a))
            return '0;
        else if (we_eff && (a == wa_eff))
            return wd_eff;
        else
            return mem[a];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
            rd_data_a <= '0;
            rd_data_b <= '0;
            for (int i = 0; i < depth; i++) mem[i] <= '0;
        end else begin
            if (we_eff) mem[wa_eff] <= wd_eff;
            if (rd_en_a) rd_data_a <= rd_val(rd_addr_a);
            if (rd_en_b) rd_data_b <= rd_val(rd_addr_b);

            if (state == IDLE) begin
                if (clr) begin
                    state <= CLEAR;
                    busy  <= 1'b1;
                    cnt   <= '0;
                end
            end else begin
                if (cnt == last_idx) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef REG_FILE_PARITY_EN
    logic par [depth];
    logic wp_eff;

    // Even parity over the data; injection flips the stored bit. Clear stores a consistent zero.
    assign wp_eff = clearing ? 1'b0 : ((^wr_data) ^ par_inj);

    function automatic logic rd_perr(input logic [aw-1:0] a);
        if (!in_range(a))
            return 1'b0;
        else if (we_eff && (a == wa_eff))
            return (^wd_eff) != wp_eff;
        else
            return (^mem[a]) != par[a];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_perr_a <= 1'b0;
            rd_perr_b <= 1'b0;
            for (int i = 0; i < depth; i++) par[i] <= 1'b0;
        end else begin
            if (we_eff) par[wa_eff] <= wp_eff;
            if (rd_en_a) rd_perr_a <= rd_perr(rd_addr_a);
            if (rd_en_b) rd_perr_b <= rd_perr(rd_addr_b);
        end
    end
`endif

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Parametrised successor to the single-port register file: one write port, two independent registered read ports, configurable width and depth.
- Write-first bypass, out-of-range address handling, and a hardware clear sequencer that zeroes the array one entry per cycle.
- Sits between datapath units needing two operands per cycle (e.g. ALU operand fetch) and a single result writer.

Parameters:
- width, 8, data bits per entry.
- depth, 8, number of entries (need not be a power of two, minimum 2).
- aw, $clog2(depth), address width (derived; not to be overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- wr_en  input  1  write enable.
- wr_addr  input  aw  write address.
- wr_data  input  width  write data.
- rd_en_a  input  1  read enable, port A.
- rd_addr_a  input  aw  read address, port A.
- rd_data_a  output  width  registered read data, port A.
- rd_en_b  input  1  read enable, port B.
- rd_addr_b  input  aw  read address, port B.
- rd_data_b  output  width  registered read data, port B.
- clr  input  1  clear request pulse.
- busy  output  1  clear sequence in progress.

Behaviour:
- Reset (rst=0, async): all entries=0, rd_data_a=rd_data_b=0, busy=0, FSM=IDLE, clear counter=0.
- Write: wr_en=1 and wr_addr<depth in IDLE -> mem[wr_addr]<=wr_data at posedge. wr_addr>=depth -> write dropped, no side effect.
- Read latency 1: rd_en_x=1 -> rd_data_x valid the cycle after, from the posedge sample. rd_en_x=0 -> rd_data_x holds its previous value.
- Read with rd_addr_x>=depth -> rd_data_x<=0.
- Bypass (write-first):
  - A read with rd_en_x=1, rd_addr_x==wr_addr and an accepted write in the same cycle returns wr_data, not the old contents.
  - Both ports may bypass simultaneously.
  - Both ports may read the same address simultaneously.
- FSM IDLE -> CLEAR:
  - clr=1 in IDLE -> next cycle state=CLEAR, busy=1, counter=0.
  - Writes are accepted in the same cycle clr is sampled.
- FSM CLEAR:
  - Each cycle mem[counter]<=0 and counter increments.
  - After the write at counter=depth-1 -> IDLE; busy deasserts the following cycle.
  - busy is high for exactly depth cycles.
- During CLEAR:
  - wr_en is ignored.
  - clr is ignored.
  - Reads are serviced normally.
  - A read of the entry being cleared that cycle returns 0 (bypass applies to clear writes).
- Reset mid-CLEAR: immediate return to IDLE, busy=0, all entries 0.

Optional Feature:
- Macro: REG_FILE_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit computed from wr_data (clear writes store parity 0).
  - Added outputs rd_perr_a and rd_perr_b (1 bit each), registered with the same latency and hold rules as the data.
  - rd_perr_x=1 when the stored parity mismatches the stored data.
  - Added input par_inj (1 bit): when 1 with an accepted write, the stored parity bit is inverted (error injection).
  - Bypassed reads check parity against the parity stored for that write, including any injection.
  - Out-of-range reads give rd_perr_x=0.
  - Reset clears all parity bits and rd_perr_x.
- Undefined: no parity storage and no rd_perr_a, rd_perr_b or par_inj ports. Behaviour is otherwise identical.

Test Plan:
- Reset, then write addr 0..7 with data 8'h10+k, then read A=k, B=7-k each cycle -> one cycle later rd_data_a=8'h10+k, rd_data_b=8'h17-k.
- Same cycle: wr_en=1, wr_addr=3, wr_data=8'hA5, rd_en_a=rd_en_b=1, rd_addr_a=rd_addr_b=3 -> next cycle both rd_data=8'hA5.
- depth=6: write addr 7 with 8'hFF, then read addr 7 -> rd_data=0; entries 0..5 unchanged.
- Fill all entries, pulse clr, attempt wr_en to addr 2 during CLEAR -> busy high exactly 8 cycles; afterwards every read returns 0; write ignored.
- Assert rst=0 at the 4th cycle of CLEAR -> busy=0 and rd_data=0 immediately (asynchronous); after release, reads of all entries return 0.
- REG_FILE_PARITY_EN: write addr 1 = 8'h3C with par_inj=1, read addr 1 -> rd_perr_a=1; rewrite with par_inj=0 -> rd_perr_a=0.
